// File: rtl/pipe_fetch_unit_if.sv
// Instruction-memory fetch port between the IF stage (master) and memory (slave).
// Ready-handshaked: a fetch completes on any cycle with imem_req and imem_ready both high.
interface pipe_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/pipe_fetch_unit.sv
// IF stage: owns the PC and the IF/ID register, fetches over a ready-handshaked port,
// and applies ID redirects with single-delay-slot semantics.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   FETCH | request outstanding at pc; result goes to IF/ID unless ID stalls
//   HOLD  | fetched word parked in ibuf while ID stalls; no request issued
module pipe_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        bpc,
    input  logic [31:0]        rpc,
    input  logic [31:0]        jpc,
    input  logic [1:0]         pcsource,
    input  logic               wpcir,
    pipe_fetch_unit_if.master  imem,
    output logic [31:0]        pc,
    output logic [31:0]        inst,
    output logic [31:0]        dpc4,
    output logic               dvalid
);

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] dpc4_q, dpc4_d;
    logic        dvalid_q, dvalid_d;
    logic [31:0] ibuf_q, ibuf_d;
    logic [31:0] pend_pc_q, pend_pc_d;
    logic        pend_valid_q, pend_valid_d;

    logic        imem_req_c;
    logic        f_done;
    logic        id_hold;
    logic        d_fire;
    logic        redir;
    logic        pc_load;
    logic [31:0] tgt;
    logic [31:0] pc_plus4;
    logic [31:0] npc;

    assign imem.imem_req  = imem_req_c;
    assign imem.imem_addr = pc_q;
    assign pc             = pc_q;
    assign inst           = inst_q;
    assign dpc4           = dpc4_q;
    assign dvalid         = dvalid_q;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        dpc4_d       = dpc4_q;
        dvalid_d     = dvalid_q;
        ibuf_d       = ibuf_q;
        pend_pc_d    = pend_pc_q;
        pend_valid_d = pend_valid_q;
        pc_load      = 1'b0;

        imem_req_c = (state_q == FETCH) && !reset;
        f_done     = imem_req_c && imem.imem_ready;
        id_hold    = dvalid_q && wpcir;
        d_fire     = dvalid_q && !wpcir;
        // A redirect arriving while one is already pending cannot be legal; drop it.
        redir      = d_fire && (pcsource != 2'b00) && !pend_valid_q;

        case (pcsource)
            2'b01:   tgt = bpc;
            2'b10:   tgt = rpc;
            2'b11:   tgt = jpc;
            default: tgt = pc_q + 32'd4;
        endcase

        pc_plus4 = pc_q + 32'd4;
        if (redir)
            npc = tgt;
        else if (pend_valid_q)
            npc = pend_pc_q;
        else
            npc = pc_plus4;

        case (state_q)
            FETCH: begin
                if (f_done && !id_hold) begin
                    inst_d   = imem.imem_rdata;
                    dpc4_d   = pc_plus4;
                    dvalid_d = 1'b1;
                    pc_load  = 1'b1;
                end else if (f_done) begin
                    ibuf_d  = imem.imem_rdata;
                    state_d = HOLD;
                end else if (!id_hold) begin
                    // Bubble so the instruction just consumed by ID is not re-issued.
                    inst_d   = 32'h0000_0000;
                    dvalid_d = 1'b0;
                end
            end
            HOLD: begin
                if (!id_hold) begin
                    inst_d   = ibuf_q;
                    dpc4_d   = pc_plus4;
                    dvalid_d = 1'b1;
                    pc_load  = 1'b1;
                    state_d  = FETCH;
                end
            end
            default: state_d = FETCH;
        endcase

        // The fetch at pc is the delay slot; a redirect seen before it completes waits here.
        if (pc_load) begin
            pc_d         = npc;
            pend_valid_d = 1'b0;
        end else if (redir) begin
            pend_pc_d    = tgt;
            pend_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            inst_q       <= 32'h0000_0000;
            dpc4_q       <= 32'h0000_0000;
            dvalid_q     <= 1'b0;
            ibuf_q       <= 32'h0000_0000;
            pend_pc_q    <= 32'h0000_0000;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            dpc4_q       <= dpc4_d;
            dvalid_q     <= dvalid_d;
            ibuf_q       <= ibuf_d;
            pend_pc_q    <= pend_pc_d;
            pend_valid_q <= pend_valid_d;
        end
    end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Cycle-by-cycle vector bench for pipe_fetch_unit: each record gives one cycle's inputs
// and the outputs expected during that cycle, queued at drive time and checked before the edge.
module tb_pipe_fetch_unit;

    logic        clock;
    logic        reset;
    logic [31:0] bpc, rpc, jpc;
    logic [1:0]  pcsource;
    logic        wpcir;
    logic [31:0] pc, inst, dpc4;
    logic        dvalid;

    pipe_fetch_unit_if bus ();

    pipe_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clock    (clock),
        .reset    (reset),
        .bpc      (bpc),
        .rpc      (rpc),
        .jpc      (jpc),
        .pcsource (pcsource),
        .wpcir    (wpcir),
        .imem     (bus.master),
        .pc       (pc),
        .inst     (inst),
        .dpc4     (dpc4),
        .dvalid   (dvalid)
    );

    // Memory model: word = addr | 0x1000 when ready, garbage otherwise.
    assign bus.imem_rdata = bus.imem_ready ? (bus.imem_addr | 32'h0000_1000) : 32'hDEAD_BEEF;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        rst;
        logic        rdy;
        logic        wp;
        logic [1:0]  ps;
        logic [31:0] tgt;
        logic        req;
        logic [31:0] addr;
        logic [31:0] inst;
        logic [31:0] dpc4;
        logic        dv;
    } vec_t;

    vec_t tv[$];
    vec_t exp_q[$];
    int   n_tests;
    int   n_fail;

    function automatic vec_t mk(logic rst, logic rdy, logic wp, logic [1:0] ps, logic [31:0] tgt,
                                logic req, logic [31:0] addr, logic [31:0] ins,
                                logic [31:0] d4, logic dv);
        vec_t v;
        v.rst = rst; v.rdy = rdy; v.wp = wp; v.ps = ps; v.tgt = tgt;
        v.req = req; v.addr = addr; v.inst = ins; v.dpc4 = d4; v.dv = dv;
        return v;
    endfunction

    task automatic chk(input int idx, input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL cycle%0d %s: got %h want %h", idx, name, got, want);
        end
    endtask

    task automatic apply(input int idx, input vec_t v);
        vec_t e;
        @(negedge clock);
        reset          = v.rst;
        bus.imem_ready = v.rdy;
        wpcir          = v.wp;
        pcsource       = v.ps;
        bpc            = (v.ps == 2'b01) ? v.tgt : 32'h0BAD_0010;
        rpc            = (v.ps == 2'b10) ? v.tgt : 32'h0BAD_0020;
        jpc            = (v.ps == 2'b11) ? v.tgt : 32'h0BAD_0030;
        exp_q.push_back(v);
        #1;
        e = exp_q.pop_front();
        chk(idx, "imem_req",  {31'd0, bus.imem_req}, {31'd0, e.req});
        chk(idx, "imem_addr", bus.imem_addr,         e.addr);
        chk(idx, "inst",      inst,                  e.inst);
        chk(idx, "dpc4",      dpc4,                  e.dpc4);
        chk(idx, "dvalid",    {31'd0, dvalid},       {31'd0, e.dv});
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset = 1'b1; bus.imem_ready = 1'b1; wpcir = 1'b0; pcsource = 2'b00;
        bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
        @(negedge clock);

        //           rst rdy wp ps tgt            req addr          inst           dpc4           dv
        tv.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h000,       32'h0,         32'h000,       0)); // reset state
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h000,       32'h0,         32'h000,       0)); // zero-wait stream
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h004,       32'h1000,      32'h004,       1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h008,       32'h1004,      32'h008,       1)); // wait states at 0x8
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        1, 32'h008,       32'h0,         32'h008,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h008,       32'h0,         32'h008,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h00C,       32'h1008,      32'h00C,       1)); // stall, fetch done
        tv.push_back(mk(0, 0, 1, 0, 32'h0,        0, 32'h00C,       32'h1008,      32'h00C,       1));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        0, 32'h00C,       32'h1008,      32'h00C,       1));
        tv.push_back(mk(0, 0, 0, 0, 32'h0,        0, 32'h00C,       32'h1008,      32'h00C,       1)); // release HOLD
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h010,       32'h100C,      32'h010,       1));
        tv.push_back(mk(0, 1, 0, 1, 32'h40,       1, 32'h014,       32'h1010,      32'h014,       1)); // zero-wait branch
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h040,       32'h1014,      32'h018,       1));
        tv.push_back(mk(0, 0, 0, 3, 32'h100,      1, 32'h044,       32'h1040,      32'h044,       1)); // delayed jump
        tv.push_back(mk(0, 0, 0, 3, 32'h200,      1, 32'h044,       32'h0,         32'h044,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h044,       32'h0,         32'h044,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h100,       32'h1044,      32'h048,       1));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h104,       32'h1100,      32'h104,       1));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h108,       32'h1104,      32'h108,       1));
        tv.push_back(mk(0, 0, 0, 1, 32'h300,      1, 32'h10C,       32'h1108,      32'h10C,       1)); // pend, then reset
        tv.push_back(mk(1, 1, 0, 0, 32'h0,        0, 32'h10C,       32'h0,         32'h10C,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h000,       32'h0,         32'h000,       0));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h004,       32'h1000,      32'h004,       1)); // HOLD, then reset
        tv.push_back(mk(1, 0, 1, 0, 32'h0,        0, 32'h004,       32'h1000,      32'h004,       1));
        tv.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h000,       32'h0,         32'h000,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h000,       32'h0,         32'h000,       0));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h004,       32'h1000,      32'h004,       1));
        tv.push_back(mk(0, 1, 1, 0, 32'h0,        1, 32'h008,       32'h1004,      32'h008,       1)); // jr on HOLD release
        tv.push_back(mk(0, 0, 0, 2, 32'h500,      0, 32'h008,       32'h1004,      32'h008,       1));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h500,       32'h1008,      32'h00C,       1));
        tv.push_back(mk(0, 0, 1, 0, 32'h0,        1, 32'h504,       32'h1500,      32'h504,       1)); // stall, fetch waiting
        tv.push_back(mk(0, 0, 1, 1, 32'h900,      1, 32'h504,       32'h1500,      32'h504,       1));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h504,       32'h1500,      32'h504,       1));
        tv.push_back(mk(0, 1, 0, 0, 32'h0,        1, 32'h508,       32'h1504,      32'h508,       1));

        for (int i = 0; i < tv.size(); i++)
            apply(i, tv[i]);

        // PC wraps past the top of the address space.
        apply(100, mk(0, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h50C,       32'h1508,      32'h50C,       1));
        apply(101, mk(0, 1, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 32'h150C,      32'h510,       1));
        apply(102, mk(0, 1, 0, 0, 32'h0,         1, 32'h000,       32'hFFFF_FFFC, 32'h000,       1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
